wb_port_arbiter: RTL and testbench
==================================

// Module: wb_port_arbiter
// PURPOSE
//  Shares the single register-file write port between the in-order write-back stage and a
//  long-latency unit (mul/div, late loads). Pipeline write-back has default priority. LL results
//  are buffered in a small FIFO, with optional same-cycle bypass. A starvation counter forces
//  LL drains and stalls the pipe.
//  Sits between write_back / LL unit outputs and the register-file write port.
// PARAMETERS
//  XLEN          64  data width of register-file write
//  REG_ADDR_W    5   destination register index width
//  LL_DEPTH      2   LL result FIFO entries (power of two, >=2)
//  STARVE_LIMIT  4   consecutive cycles a non-empty FIFO may lose before forced grant (>=1)
// PORTS
//  clk           in   1           clock; all state updates on posedge
//  reset         in   1           synchronous, active-high
//  pipe_valid    in   1           write-back stage has a result this cycle
//  pipe_rd       in   REG_ADDR_W  write-back destination (rd from write_back)
//  pipe_data     in   XLEN        write-back data (result_write_back)
//  pipe_stall    out  1           pipe result not accepted; pipe holds inputs stable
//  ll_valid      in   1           LL unit offers a result
//  ll_ready      out  1           arbiter accepts LL result this cycle
//  ll_rd         in   REG_ADDR_W  LL destination register
//  ll_data       in   XLEN        LL result data
//  rf_we         out  1           register-file write enable
//  rf_rd         out  REG_ADDR_W  register-file write address
//  rf_wdata      out  XLEN        register-file write data
//  perf_stall_cnt  out 32         pipe stall cycles (see CONFIGURATION)
//  perf_bypass_cnt out 32         LL bypass writes (see CONFIGURATION)
// BEHAVIOUR
//  - Reset is synchronous and active-high. It clears the FIFO (count=0, pointers=0) and sets
//    starve_cnt=0. While reset is high: rf_we=0, pipe_stall=0, ll_ready=0. Perf counters reset to 0.
//  - Writes to x0 are never performed:
//      * pipe_valid with pipe_rd==0 is a non-request and is never stalled.
//      * An accepted LL result with ll_rd==0 is discarded (not enqueued, no write).
//  - ll_ready = !reset && (count < LL_DEPTH). It depends only on registered state, so there is
//    no combinational path from ll_valid. LL accept = ll_valid && ll_ready.
//  - Grant per cycle (combinational, zero latency; rf_* driven the same cycle):
//      1. FORCE_LL: count>0 && starve_cnt==STARVE_LIMIT -> FIFO head writes; pipe_stall=pipe req.
//      2. PIPE:     pipe req (valid, rd!=0) -> pipe writes; pipe_stall=0.
//      3. DRAIN:    count>0 -> FIFO head writes.
//      4. BYPASS:   count==0 && LL accept && ll_rd!=0 -> LL writes directly; not enqueued.
//      5. IDLE:     rf_we=0; rf_rd and rf_wdata are 0.
//  - Enqueue: LL accept, ll_rd!=0, and not BYPASS. Enqueue and dequeue in the same cycle are
//    legal at any count; count changes by +1, -1, or 0 accordingly.
//  - Pointers wrap modulo LL_DEPTH.
//  - starve_cnt (registered):
//      * Reset to 0 when count==0 (next state) or when the FIFO is granted.
//      * Otherwise incremented if count>0 and the pipe won, saturating at STARVE_LIMIT.
//  - FORCE_LL thus occurs at most once per STARVE_LIMIT+1 cycles under a continuous pipe stream.
//  - Ordering: FIFO drains strictly in arrival order.
//  - Precondition: the hazard unit guarantees pipe and LL never target the same rd concurrently.
//    The arbiter does not check this.
//  - Full FIFO + ll_valid: ll_ready=0; the LL unit holds its data. No loss, no overwrite.
//  - Reset mid-operation discards all buffered LL results. The LL unit must be reset in the
//    same cycle.
// CONFIGURATION
//  WB_ARB_PERF_CNT_EN defined:
//    - perf_stall_cnt increments each cycle pipe_stall=1.
//    - perf_bypass_cnt increments each BYPASS grant.
//    - Both are 32-bit, saturating at 32'hFFFF_FFFF, cleared by reset.
//  Not defined: both ports are tied to 0, and no counter flops are instantiated.
// STRUCTURE
//  Package wb_arb_pkg:
//    - XLEN and REG_ADDR_W constants.
//    - typedef wb_req_t {rd, data}.
//    - enum wb_grant_e {GNT_IDLE, GNT_PIPE, GNT_DRAIN, GNT_FORCE_LL, GNT_BYPASS}.
//  Sub-module wb_arb_fifo: LL_DEPTH-entry FIFO of wb_req_t with push/pop/count/full/empty and
//  pointer wrap. The arbitration and starvation logic stays in this module.
// TESTING
//  1. Reset held 2 cycles with pipe_valid=1 and ll_valid=1 -> rf_we=0, ll_ready=0,
//     pipe_stall=0; cycle after release ll_ready=1.
//  2. Idle pipe, ll_valid with rd=5, data=0xAB -> same cycle rf_we=1, rf_rd=5, rf_wdata=0xAB
//     (BYPASS); count stays 0; perf_bypass_cnt=1 if enabled.
//  3. Continuous pipe stream (rd=3) plus one LL result (rd=7) -> pipe wins 4 cycles.
//     - 5th cycle: rf_rd=7 and pipe_stall=1 (FORCE_LL).
//     - Next cycle: pipe resumes with its held data.
//  4. Continuous pipe stream, LL pushes 3 results -> first 2 accepted.
//     - ll_ready=0 while full; 3rd held until a drain frees an entry.
//     - Writes appear in order 10, 11, 12.
//  5. LL result with rd=0 while pipe is idle -> accepted (ll_ready=1), rf_we=0, count unchanged.
//     Pipe with rd=0 -> rf_we=0, pipe_stall=0.
//  6. FIFO holds 2 entries, reset asserted -> count=0 next cycle, no rf_we for the discarded
//     entries, starve_cnt=0.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared types for the register-file write-port arbiter: data widths, the
// buffered write request, the per-cycle grant encoding and a saturating
// increment used by the optional performance counters.
package wb_arb_pkg;

    localparam int XLEN       = 64;
    localparam int REG_ADDR_W = 5;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_req_t;

    typedef enum logic [2:0] {
        GNT_IDLE,
        GNT_PIPE,
        GNT_DRAIN,
        GNT_FORCE_LL,
        GNT_BYPASS
    } wb_grant_e;

    function automatic logic [31:0] sat_inc32(input logic [31:0] val);
        return (val == 32'hFFFF_FFFF) ? val : val + 32'd1;
    endfunction

endpackage

// File: rtl/wb_arb_fifo.sv
// Small in-order buffer for long-latency write-back results. DEPTH must be a
// power of two so the read/write pointers wrap by natural overflow.
module wb_arb_fifo
    import wb_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  wb_req_t                push_data,
    input  logic                   pop,
    output wb_req_t                head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_req_t            mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count_q;

    // Pointer and occupancy bookkeeping; push and pop may coincide at any fill level.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count_q <= count_q + 1'b1;
            else if (!push && pop)
                count_q <= count_q - 1'b1;
        end
    end

    // Entry storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head  = mem[rd_ptr];
    assign count = count_q;
    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between the in-order
// write-back stage and a long-latency unit. Pipe results win by default; LL
// results are buffered and forced through when they have waited too long.
// Optional feature: define WB_ARB_PERF_CNT_EN to build the stall/bypass
// performance counters (otherwise both perf ports read 0).
//
// grant        | meaning
// -------------+---------------------------------------------------------
// GNT_IDLE     | no write this cycle
// GNT_PIPE     | write-back stage result written
// GNT_DRAIN    | FIFO head written, pipe had no request
// GNT_FORCE_LL | FIFO head written after starvation, pipe stalled
// GNT_BYPASS   | LL result written directly, FIFO empty and pipe idle
module wb_port_arbiter
    import wb_arb_pkg::*;
#(
    parameter int LL_DEPTH     = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pipe_valid,
    input  logic [REG_ADDR_W-1:0] pipe_rd,
    input  logic [XLEN-1:0]       pipe_data,
    output logic                  pipe_stall,
    input  logic                  ll_valid,
    output logic                  ll_ready,
    input  logic [REG_ADDR_W-1:0] ll_rd,
    input  logic [XLEN-1:0]       ll_data,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_rd,
    output logic [XLEN-1:0]       rf_wdata,
    output logic [31:0]           perf_stall_cnt,
    output logic [31:0]           perf_bypass_cnt
);

    localparam int CNT_W = $clog2(LL_DEPTH) + 1;
    localparam int SL_W  = $clog2(STARVE_LIMIT + 1);
    localparam logic [SL_W-1:0] STARVE_INIT = SL_W'(STARVE_LIMIT);

    wb_req_t          push_req;
    wb_req_t          head_req;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W-1:0] count_nxt;

    logic             pipe_req;
    logic             ll_accept;
    logic             force_ll;
    wb_grant_e        grant;

    // Remaining pipe wins the FIFO head may lose; FIFO is forced at zero.
    logic [SL_W-1:0]  starve_left;

    assign pipe_req  = pipe_valid && (pipe_rd != '0);
    assign ll_ready  = !reset && !fifo_full;
    assign ll_accept = ll_valid && ll_ready;
    assign force_ll  = !fifo_empty && (starve_left == '0);
    assign push_req  = '{rd: ll_rd, data: ll_data};

    // Fixed-priority grant: starvation override, pipe, drain, then bypass.
    always_comb begin
        grant = GNT_IDLE;
        if (!reset) begin
            if (force_ll)
                grant = GNT_FORCE_LL;
            else if (pipe_req)
                grant = GNT_PIPE;
            else if (!fifo_empty)
                grant = GNT_DRAIN;
            else if (ll_accept && (ll_rd != '0))
                grant = GNT_BYPASS;
        end
    end

    // Drive the write port from whichever source holds the grant.
    always_comb begin
        rf_we    = 1'b0;
        rf_rd    = '0;
        rf_wdata = '0;
        unique case (grant)
            GNT_PIPE: begin
                rf_we    = 1'b1;
                rf_rd    = pipe_rd;
                rf_wdata = pipe_data;
            end
            GNT_DRAIN, GNT_FORCE_LL: begin
                rf_we    = 1'b1;
                rf_rd    = head_req.rd;
                rf_wdata = head_req.data;
            end
            GNT_BYPASS: begin
                rf_we    = 1'b1;
                rf_rd    = ll_rd;
                rf_wdata = ll_data;
            end
            default: ;
        endcase
    end

    assign pipe_stall = (grant == GNT_FORCE_LL) && pipe_req;
    assign fifo_pop   = (grant == GNT_FORCE_LL) || (grant == GNT_DRAIN);
    // x0 results are accepted but dropped; bypassed results skip the FIFO.
    assign fifo_push  = ll_accept && (ll_rd != '0) && (grant != GNT_BYPASS);

    // Occupancy after this cycle, used to rearm the starvation timer.
    always_comb begin
        count_nxt = fifo_count;
        if (fifo_push && !fifo_pop)
            count_nxt = fifo_count + 1'b1;
        else if (!fifo_push && fifo_pop)
            count_nxt = fifo_count - 1'b1;
    end

    // Starvation timer: counts down on each pipe win over a waiting FIFO head.
    always_ff @(posedge clk) begin
        if (reset)
            starve_left <= STARVE_INIT;
        else if ((count_nxt == '0) || fifo_pop)
            starve_left <= STARVE_INIT;
        else if (!fifo_empty && (grant == GNT_PIPE) && (starve_left != '0))
            starve_left <= starve_left - 1'b1;
    end

    wb_arb_fifo #(
        .DEPTH (LL_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (push_req),
        .pop       (fifo_pop),
        .head      (head_req),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

`ifdef WB_ARB_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] bypass_cnt_q;

    // Saturating event counters for stall cycles and bypass writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q  <= '0;
            bypass_cnt_q <= '0;
        end else begin
            if (pipe_stall)           stall_cnt_q  <= sat_inc32(stall_cnt_q);
            if (grant == GNT_BYPASS)  bypass_cnt_q <= sat_inc32(bypass_cnt_q);
        end
    end

    assign perf_stall_cnt  = stall_cnt_q;
    assign perf_bypass_cnt = bypass_cnt_q;
`else
    assign perf_stall_cnt  = 32'd0;
    assign perf_bypass_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for the write-port arbiter: reset, bypass, starvation force,
// FIFO full back-pressure and ordering, x0 suppression, and reset discard.
module tb_wb_port_arbiter;
    import wb_arb_pkg::*;

`ifdef WB_ARB_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  pipe_valid;
    logic [REG_ADDR_W-1:0] pipe_rd;
    logic [XLEN-1:0]       pipe_data;
    logic                  pipe_stall;
    logic                  ll_valid;
    logic                  ll_ready;
    logic [REG_ADDR_W-1:0] ll_rd;
    logic [XLEN-1:0]       ll_data;
    logic                  rf_we;
    logic [REG_ADDR_W-1:0] rf_rd;
    logic [XLEN-1:0]       rf_wdata;
    logic [31:0]           perf_stall_cnt;
    logic [31:0]           perf_bypass_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    wb_port_arbiter #(
        .LL_DEPTH     (2),
        .STARVE_LIMIT (4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .pipe_valid      (pipe_valid),
        .pipe_rd         (pipe_rd),
        .pipe_data       (pipe_data),
        .pipe_stall      (pipe_stall),
        .ll_valid        (ll_valid),
        .ll_ready        (ll_ready),
        .ll_rd           (ll_rd),
        .ll_data         (ll_data),
        .rf_we           (rf_we),
        .rf_rd           (rf_rd),
        .rf_wdata        (rf_wdata),
        .perf_stall_cnt  (perf_stall_cnt),
        .perf_bypass_cnt (perf_bypass_cnt)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1, "timeout");
    end

    wb_req_t ll_q [$];
    logic [REG_ADDR_W-1:0] got_rd [$];
    logic [XLEN-1:0]       got_data [$];
    int  saw_full;
    int  stall_hits;
    int  pipe_wins;
    bit  acc;
    bit  seen_ll;

    initial begin
        // Test 1: reset held with both sources requesting
        reset      = 1'b1;
        pipe_valid = 1'b1; pipe_rd = 5'd1; pipe_data = 64'h1;
        ll_valid   = 1'b1; ll_rd   = 5'd2; ll_data   = 64'h2;
        #1;
        for (int i = 0; i < 2; i++) begin
            settle();
            check_val("t1_rst_rf_we", rf_we, 0);
            check_val("t1_rst_ll_ready", ll_ready, 0);
            check_val("t1_rst_pipe_stall", pipe_stall, 0);
            next_cycle();
        end
        reset = 1'b0; pipe_valid = 1'b0; ll_valid = 1'b0;
        settle();
        check_val("t1_ll_ready_after", ll_ready, 1);
        check_val("t1_rf_we_after", rf_we, 0);
        check_val("t1_count", dut.fifo_count, 0);
        check_val("t1_perf_stall", perf_stall_cnt, 0);
        check_val("t1_perf_bypass", perf_bypass_cnt, 0);

        // Test 2: bypass with idle pipe and empty FIFO
        next_cycle();
        ll_valid = 1'b1; ll_rd = 5'd5; ll_data = 64'hAB;
        settle();
        check_val("t2_rf_we", rf_we, 1);
        check_val("t2_rf_rd", rf_rd, 5);
        check_val("t2_rf_wdata", rf_wdata, 64'hAB);
        check_val("t2_pipe_stall", pipe_stall, 0);
        next_cycle();
        ll_valid = 1'b0;
        settle();
        check_val("t2_count", dut.fifo_count, 0);
        check_val("t2_rf_we_idle", rf_we, 0);
        check_val("t2_perf_bypass", perf_bypass_cnt, PERF ? 1 : 0);

        // Test 3: continuous pipe stream, one LL result, forced after 4 pipe wins
        next_cycle();
        pipe_valid = 1'b1; pipe_rd = 5'd3; pipe_data = 64'h33;
        ll_valid   = 1'b1; ll_rd   = 5'd7; ll_data   = 64'h77;
        settle();
        check_val("t3_first_rd", rf_rd, 3);
        check_val("t3_ll_ready", ll_ready, 1);
        next_cycle();
        ll_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            settle();
            check_val("t3_pipe_rd", rf_rd, 3);
            check_val("t3_pipe_nostall", pipe_stall, 0);
            next_cycle();
        end
        settle();
        check_val("t3_force_rd", rf_rd, 7);
        check_val("t3_force_data", rf_wdata, 64'h77);
        check_val("t3_force_stall", pipe_stall, 1);
        next_cycle();
        settle();
        check_val("t3_resume_rd", rf_rd, 3);
        check_val("t3_resume_data", rf_wdata, 64'h33);
        check_val("t3_resume_stall", pipe_stall, 0);
        check_val("t3_count", dut.fifo_count, 0);

        // Test 4: three LL results against a pipe stream; FIFO fills, drains in order
        ll_q.push_back('{rd: 5'd10, data: 64'h110});
        ll_q.push_back('{rd: 5'd11, data: 64'h111});
        ll_q.push_back('{rd: 5'd12, data: 64'h112});
        saw_full = 0; stall_hits = 0;
        next_cycle();
        for (int c = 0; c < 20; c++) begin
            if (ll_q.size() > 0) begin
                ll_valid = 1'b1; ll_rd = ll_q[0].rd; ll_data = ll_q[0].data;
            end else begin
                ll_valid = 1'b0;
            end
            settle();
            acc = ll_valid && ll_ready;
            if (ll_valid && !ll_ready) saw_full++;
            if (rf_we && rf_rd != 5'd3) begin
                got_rd.push_back(rf_rd);
                got_data.push_back(rf_wdata);
                if (pipe_stall) stall_hits++;
            end
            next_cycle();
            if (acc) void'(ll_q.pop_front());
        end
        ll_valid = 1'b0;
        check_val("t4_n_ll_writes", got_rd.size(), 3);
        for (int i = 0; i < got_rd.size() && i < 3; i++) begin
            check_val($sformatf("t4_order_rd%0d", i), got_rd[i], 64'(10 + i));
            check_val($sformatf("t4_order_data%0d", i), got_data[i], 64'(32'h110 + i));
        end
        check_val("t4_full_cycles", saw_full, 4);
        check_val("t4_stalls", stall_hits, 3);
        check_val("t4_ll_pending", ll_q.size(), 0);
        settle();
        check_val("t4_count", dut.fifo_count, 0);
        check_val("t4_perf_stall", perf_stall_cnt, PERF ? 4 : 0);

        // Test 5: x0 destinations from either source never write
        next_cycle();
        pipe_valid = 1'b0;
        ll_valid = 1'b1; ll_rd = 5'd0; ll_data = 64'h55;
        settle();
        check_val("t5_ll_x0_ready", ll_ready, 1);
        check_val("t5_ll_x0_we", rf_we, 0);
        next_cycle();
        ll_valid = 1'b0;
        settle();
        check_val("t5_ll_x0_count", dut.fifo_count, 0);
        next_cycle();
        pipe_valid = 1'b1; pipe_rd = 5'd0; pipe_data = 64'h99;
        settle();
        check_val("t5_pipe_x0_we", rf_we, 0);
        check_val("t5_pipe_x0_stall", pipe_stall, 0);
        check_val("t5_perf_bypass", perf_bypass_cnt, PERF ? 1 : 0);

        // Test 6: reset discards a full FIFO and rearms the starvation timer
        next_cycle();
        pipe_valid = 1'b1; pipe_rd = 5'd3; pipe_data = 64'h33;
        ll_valid = 1'b1; ll_rd = 5'd20; ll_data = 64'h220;
        settle();
        next_cycle();
        ll_rd = 5'd21; ll_data = 64'h221;
        settle();
        check_val("t6_ll_ready_one", ll_ready, 1);
        next_cycle();
        ll_valid = 1'b0;
        settle();
        check_val("t6_count_full", dut.fifo_count, 2);
        next_cycle();
        reset = 1'b1; pipe_valid = 1'b0;
        settle();
        check_val("t6_rst_we", rf_we, 0);
        check_val("t6_rst_ll_ready", ll_ready, 0);
        next_cycle();
        reset = 1'b0;
        settle();
        check_val("t6_count_cleared", dut.fifo_count, 0);
        check_val("t6_no_discard_write", rf_we, 0);
        check_val("t6_perf_stall_clr", perf_stall_cnt, 0);
        check_val("t6_perf_bypass_clr", perf_bypass_cnt, 0);
        next_cycle();
        settle();
        check_val("t6_still_idle", rf_we, 0);

        // After reset a fresh LL result again waits exactly 4 pipe wins
        next_cycle();
        pipe_valid = 1'b1; pipe_rd = 5'd3; pipe_data = 64'h33;
        ll_valid = 1'b1; ll_rd = 5'd9; ll_data = 64'h99;
        settle();
        next_cycle();
        ll_valid = 1'b0;
        pipe_wins = 0; seen_ll = 1'b0;
        for (int c = 0; c < 10 && !seen_ll; c++) begin
            settle();
            if (rf_we && rf_rd == 5'd9) seen_ll = 1'b1;
            else if (rf_we && rf_rd == 5'd3) pipe_wins++;
            next_cycle();
        end
        check_val("t6_ll_forced", seen_ll, 1);
        check_val("t6_pipe_wins", pipe_wins, 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
